dp_instr_sequencer: RTL and testbench
=====================================

Name: dp_instr_sequencer

Overview:
Multi-cycle control sequencer that drives the DataPath instruction/data inputs and register-file select; it is the initiating end of the ir/data/select interface.
- Accepts 32-bit instructions through a valid/ready handshake.
- Sequences the register-file read phase, ALU result capture and register write-back, holding each phase stable for a programmable number of cycles.
- Returns the written value to the requester.
- Sits between the instruction source (fetch unit or test driver) and the DataPath.

Parameters:
WIDTH, 32, data/instruction word width
HOLD_CYCLES, 4, cycles each datapath phase is held stable (legal range 1..255)
LOAD_OP, 6'h3F, opcode meaning "write imm_in to rd" with no read/ALU phase

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  asynchronous, active-low reset
instr_in  input  WIDTH  instruction: [31:26] opcode, [25:21] rd, [20:16] rs, [15:11] rt
imm_in  input  WIDTH  immediate for LOAD_OP, sampled with instr_in
instr_valid  input  1  requester has an instruction
instr_ready  output  1  sequencer can accept (IDLE only)
ir_out  output  WIDTH  instruction word to DataPath
data_out  output  WIDTH  write data to DataPath register file
reg_file_select  output  1  1 = register-file write, 0 = read
alu_result  input  WIDTH  ALU output from DataPath
result_out  output  WIDTH  value written to rd for the last completed instruction
result_valid  output  1  one-cycle pulse: result_out is valid
busy  output  1  high in every non-IDLE state

Behaviour:
- Reset (async assert, sync-released by the flops):
  - state IDLE, counter 0.
  - ir_out, data_out, result_out = 0; reg_file_select = 0; result_valid = 0.
  - instr_ready = 1 after release.
- Handshake: accept when instr_valid && instr_ready at a rising edge.
  - instr_in and imm_in are latched into instr_q and imm_q.
  - ir_out = instr_q from the next cycle.
  - instr_in is ignored while busy.
- States: IDLE, READ, WRITE.
- IDLE:
  - instr_ready = 1, reg_file_select = 0, data_out holds its last value.
  - On accept: opcode == LOAD_OP goes to WRITE with data_out = imm_q; any other opcode goes to READ.
- READ:
  - reg_file_select = 0; ir_out presents rs/rt; lasts exactly HOLD_CYCLES cycles.
  - On the last cycle (counter == HOLD_CYCLES-1), alu_result is sampled into data_out; next state is WRITE.
- WRITE:
  - reg_file_select = 1; data_out stable; lasts HOLD_CYCLES cycles.
  - After the last cycle: return to IDLE, result_out = data_out, result_valid = 1 for exactly the first IDLE cycle.
- Counter:
  - Width $clog2(HOLD_CYCLES+1); cleared on every state entry; no wrap inside a phase.
  - HOLD_CYCLES = 1 gives one-cycle phases.
- Latency, accept edge = cycle 0:
  - ALU op: READ cycles 1..H, WRITE cycles H+1..2H, result_valid and instr_ready in cycle 2H+1.
  - LOAD_OP: WRITE cycles 1..H, result_valid in cycle H+1.
- Back-to-back: accepting in the same cycle result_valid is high is legal; the pulse is not extended.
- reg_file_select and data_out never change mid-phase; ir_out changes only on accept.
- rst_n asserted mid-operation: immediate return to IDLE with reset values. No result_valid pulse and no further write; the in-flight instruction is dropped.
- opcode LOAD_OP with rd = 0 is still written (the DataPath decides on R0 semantics).

Decomposition:
- Shared package dp_pkg:
  - state enum (IDLE/READ/WRITE)
  - IR field bit positions (OP_MSB=31, OP_LSB=26, RD 25:21, RS 20:16, RT 15:11)
  - LOAD_OP default
- The phase counter is the one natural sub-module, dp_phase_timer: load/clear plus a done flag at HOLD_CYCLES-1.
- The FSM stays in dp_instr_sequencer.

Test Plan:
- Reset release, then hold instr_valid=0 for 10 cycles -> instr_ready=1, busy=0, reg_file_select=0, all data outputs 0, result_valid never high.
- HOLD=4, LOAD_OP instr with rd=0, imm_in=32'h1 -> reg_file_select=1 for cycles 1..4, data_out=1, result_valid pulse in cycle 5 with result_out=1.
- HOLD=4, ADD (opcode 0, rd=2, rs=0, rt=1), alu_result driven 32'h2 -> reg_file_select 0 for cycles 1..4, 1 for cycles 5..8, data_out=2 from cycle 5, result_valid in cycle 9 with result_out=2.
- instr_valid held high with two ADDs back-to-back -> second accepted in cycle 9 (same cycle as first result_valid); second result_valid in cycle 18; instr_in changes during busy are ignored.
- rst_n pulsed low in cycle 6 of an ADD -> outputs 0 asynchronously, no result_valid afterwards, instr_ready=1 after release.
- HOLD_CYCLES=1 build, ADD -> READ cycle 1, WRITE cycle 2, result_valid cycle 3.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared definitions for the DataPath instruction sequencer: FSM states,
// instruction-register field positions and the default load opcode.
package dp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RD_MSB = 25;
    localparam int RD_LSB = 21;
    localparam int RS_MSB = 20;
    localparam int RS_LSB = 16;
    localparam int RT_MSB = 15;
    localparam int RT_LSB = 11;

    localparam logic [5:0] LOAD_OP_DEFAULT = 6'h3F;

endpackage

// File: rtl/dp_phase_timer.sv
// Phase timer: counts cycles spent in the current datapath phase and flags
// the last cycle. Saturates at the last count so a phase never wraps.
module dp_phase_timer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic done
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] count_r;

    // Phase cycle counter: cleared on phase entry, holds at the last count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (count_r != LAST_C) begin
            count_r <= count_r + 1'b1;
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == LAST_C);

endmodule

// File: rtl/dp_instr_sequencer.sv
// Multi-cycle sequencer driving the DataPath ir/data/select interface:
// read phase, ALU capture, write-back, then result handed back to the requester.
module dp_instr_sequencer
    import dp_pkg::*;
#(
    parameter int         WIDTH       = 32,
    parameter int         HOLD_CYCLES = 4,
    parameter logic [5:0] LOAD_OP     = LOAD_OP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] instr_in,
    input  logic [WIDTH-1:0] imm_in,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [WIDTH-1:0] ir_out,
    output logic [WIDTH-1:0] data_out,
    output logic             reg_file_select,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] result_out,
    output logic             result_valid,
    output logic             busy
);

    state_e state_r;
    state_e state_next_s;

    logic             accept_s;
    logic             is_load_s;
    logic             phase_done_s;
    logic             timer_clear_s;

    logic [WIDTH-1:0] instr_q_r;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] result_r;
    logic             sel_r;
    logic             result_valid_r;
    logic             ready_r;
    logic             busy_r;

    logic [WIDTH-1:0] data_next_s;
    logic [WIDTH-1:0] result_next_s;
    logic             sel_next_s;
    logic             result_valid_next_s;

    assign accept_s  = instr_valid && ready_r;
    assign is_load_s = (instr_in[OP_MSB:OP_LSB] == LOAD_OP);

    // Idle keeps the timer parked so every phase starts counting from zero.
    assign timer_clear_s = (state_next_s != state_r) || (state_r == ST_IDLE);

    dp_phase_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_phase_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (timer_clear_s),
        .done  (phase_done_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (is_load_s) begin
                        state_next_s = ST_WRITE;
                    end else begin
                        state_next_s = ST_READ;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (phase_done_s) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_READ;
                end
            end
            ST_WRITE: begin
                if (phase_done_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WRITE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM output logic: next values for the registered datapath outputs.
    always_comb begin
        data_next_s         = data_r;
        result_next_s       = result_r;
        result_valid_next_s = 1'b0;
        sel_next_s          = (state_next_s == ST_WRITE);
        case (state_r)
            ST_IDLE: begin
                if (accept_s && is_load_s) begin
                    data_next_s = imm_in;
                end else begin
                    data_next_s = data_r;
                end
            end
            ST_READ: begin
                if (phase_done_s) begin
                    data_next_s = alu_result;
                end else begin
                    data_next_s = data_r;
                end
            end
            ST_WRITE: begin
                if (phase_done_s) begin
                    result_next_s       = data_r;
                    result_valid_next_s = 1'b1;
                end else begin
                    result_next_s       = result_r;
                    result_valid_next_s = 1'b0;
                end
            end
            default: begin
                data_next_s = data_r;
            end
        endcase
    end

    // Output and instruction registers; ir only moves on an accepted handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q_r      <= {WIDTH{1'b0}};
            data_r         <= {WIDTH{1'b0}};
            result_r       <= {WIDTH{1'b0}};
            sel_r          <= 1'b0;
            result_valid_r <= 1'b0;
            ready_r        <= 1'b1;
            busy_r         <= 1'b0;
        end else begin
            if (accept_s) begin
                instr_q_r <= instr_in;
            end else begin
                instr_q_r <= instr_q_r;
            end
            data_r         <= data_next_s;
            result_r       <= result_next_s;
            sel_r          <= sel_next_s;
            result_valid_r <= result_valid_next_s;
            ready_r        <= (state_next_s == ST_IDLE);
            busy_r         <= (state_next_s != ST_IDLE);
        end
    end

    assign instr_ready     = ready_r;
    assign busy            = busy_r;
    assign ir_out          = instr_q_r;
    assign data_out        = data_r;
    assign reg_file_select = sel_r;
    assign result_out      = result_r;
    assign result_valid    = result_valid_r;

endmodule

// File: tb/tb_dp_instr_sequencer.sv
// Directed bench for dp_instr_sequencer: one HOLD_CYCLES=4 instance and one
// HOLD_CYCLES=1 instance, expected values worked out by hand per cycle.
module tb_dp_instr_sequencer;

    logic        clk;
    logic        rst_n;

    logic [31:0] a_instr, a_imm, a_alu;
    logic        a_valid;
    logic        a_ready, a_sel, a_rv, a_busy;
    logic [31:0] a_ir, a_data, a_result;

    logic [31:0] b_instr, b_imm, b_alu;
    logic        b_valid;
    logic        b_ready, b_sel, b_rv, b_busy;
    logic [31:0] b_ir, b_data, b_result;

    int vec_cnt;
    int miss_cnt;

    dp_instr_sequencer #(.WIDTH(32), .HOLD_CYCLES(4), .LOAD_OP(6'h3F)) dut_a (
        .clk(clk), .rst_n(rst_n), .instr_in(a_instr), .imm_in(a_imm),
        .instr_valid(a_valid), .instr_ready(a_ready), .ir_out(a_ir),
        .data_out(a_data), .reg_file_select(a_sel), .alu_result(a_alu),
        .result_out(a_result), .result_valid(a_rv), .busy(a_busy)
    );

    dp_instr_sequencer #(.WIDTH(32), .HOLD_CYCLES(1), .LOAD_OP(6'h3F)) dut_b (
        .clk(clk), .rst_n(rst_n), .instr_in(b_instr), .imm_in(b_imm),
        .instr_valid(b_valid), .instr_ready(b_ready), .ir_out(b_ir),
        .data_out(b_data), .reg_file_select(b_sel), .alu_result(b_alu),
        .result_out(b_result), .result_valid(b_rv), .busy(b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a_idle_zero(input string tag);
        chk({tag, ".ready"}, {31'd0, a_ready}, 32'd1);
        chk({tag, ".busy"},  {31'd0, a_busy},  32'd0);
        chk({tag, ".sel"},   {31'd0, a_sel},   32'd0);
        chk({tag, ".rv"},    {31'd0, a_rv},    32'd0);
        chk({tag, ".ir"},     a_ir,     32'd0);
        chk({tag, ".data"},   a_data,   32'd0);
        chk({tag, ".result"}, a_result, 32'd0);
    endtask

    initial begin
        vec_cnt  = 0;
        miss_cnt = 0;
        a_instr = 32'd0; a_imm = 32'd0; a_alu = 32'd0; a_valid = 1'b0;
        b_instr = 32'd0; b_imm = 32'd0; b_alu = 32'd0; b_valid = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk_a_idle_zero("in_reset");
        chk("in_reset.b_data", b_data, 32'd0);
        #10 rst_n = 1'b1;

        // Idle for 10 cycles after release.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_a_idle_zero("idle");
        end

        // LOAD_OP, rd=0, imm=1 on H=4.
        a_instr = 32'hFC00_0000; a_imm = 32'h0000_0001; a_valid = 1'b1;
        tick();
        a_valid = 1'b0; a_imm = 32'hFFFF_FFFF;
        chk("ld.c1.sel",   {31'd0, a_sel},   32'd1);
        chk("ld.c1.data",  a_data,           32'd1);
        chk("ld.c1.busy",  {31'd0, a_busy},  32'd1);
        chk("ld.c1.ready", {31'd0, a_ready}, 32'd0);
        chk("ld.c1.ir",    a_ir,             32'hFC00_0000);
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk("ld.write.sel", {31'd0, a_sel}, 32'd1);
            chk("ld.write.rv",  {31'd0, a_rv},  32'd0);
            chk("ld.write.data", a_data,        32'd1);
        end
        tick();
        chk("ld.c5.rv",     {31'd0, a_rv},    32'd1);
        chk("ld.c5.result", a_result,         32'd1);
        chk("ld.c5.ready",  {31'd0, a_ready}, 32'd1);
        chk("ld.c5.sel",    {31'd0, a_sel},   32'd0);
        tick();
        chk("ld.c6.rv",     {31'd0, a_rv},    32'd0);
        chk("ld.c6.result", a_result,         32'd1);

        // ADD rd=2 rs=0 rt=1, alu=2 on H=4.
        a_instr = 32'h0040_0800; a_alu = 32'h0000_0002; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        chk("add.c1.ir",   a_ir,             32'h0040_0800);
        chk("add.c1.data", a_data,           32'd1);
        chk("add.c1.busy", {31'd0, a_busy},  32'd1);
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) tick();
            chk("add.read.sel", {31'd0, a_sel}, 32'd0);
        end
        tick();
        a_alu = 32'h0000_DEAD;
        chk("add.c5.sel",  {31'd0, a_sel}, 32'd1);
        chk("add.c5.data", a_data,         32'd2);
        for (int c = 6; c <= 8; c++) begin
            tick();
            chk("add.write.sel",  {31'd0, a_sel}, 32'd1);
            chk("add.write.data", a_data,         32'd2);
            chk("add.write.rv",   {31'd0, a_rv},  32'd0);
        end
        tick();
        chk("add.c9.rv",     {31'd0, a_rv},    32'd1);
        chk("add.c9.result", a_result,         32'd2);
        chk("add.c9.ready",  {31'd0, a_ready}, 32'd1);

        // Back-to-back ADDs with instr_valid held high.
        a_instr = 32'h0461_1000; a_alu = 32'h0000_0011; a_valid = 1'b1;
        tick();
        a_instr = 32'hFFFF_FFFF;
        chk("b2b.c1.ir", a_ir, 32'h0461_1000);
        for (int c = 2; c <= 7; c++) tick();
        chk("b2b.c7.ir",   a_ir,   32'h0461_1000);
        chk("b2b.c7.data", a_data, 32'h0000_0011);
        tick();
        a_instr = 32'h08A2_1800;
        chk("b2b.c8.ready", {31'd0, a_ready}, 32'd0);
        tick();
        chk("b2b.c9.rv",     {31'd0, a_rv},    32'd1);
        chk("b2b.c9.result", a_result,         32'h0000_0011);
        chk("b2b.c9.ready",  {31'd0, a_ready}, 32'd1);
        tick();
        a_valid = 1'b0; a_alu = 32'h0000_0022;
        chk("b2b.c10.rv",   {31'd0, a_rv},   32'd0);
        chk("b2b.c10.ir",   a_ir,            32'h08A2_1800);
        chk("b2b.c10.busy", {31'd0, a_busy}, 32'd1);
        chk("b2b.c10.sel",  {31'd0, a_sel},  32'd0);
        for (int c = 11; c <= 17; c++) begin
            tick();
            chk("b2b.second.rv", {31'd0, a_rv}, 32'd0);
        end
        chk("b2b.c17.sel", {31'd0, a_sel}, 32'd1);
        tick();
        chk("b2b.c18.rv",     {31'd0, a_rv}, 32'd1);
        chk("b2b.c18.result", a_result,      32'h0000_0022);
        tick();
        chk("b2b.c19.rv", {31'd0, a_rv}, 32'd0);

        // Reset pulse in cycle 6 of an ADD.
        a_instr = 32'h0040_0800; a_alu = 32'h0000_0033; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        for (int c = 2; c <= 6; c++) tick();
        chk("rst.c6.sel",  {31'd0, a_sel}, 32'd1);
        chk("rst.c6.data", a_data,         32'h0000_0033);
        rst_n = 1'b0;
        #1;
        chk_a_idle_zero("rst.async");
        #2 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk_a_idle_zero("rst.after");
        end

        // HOLD_CYCLES=1 instance, ADD with alu=0x44.
        b_instr = 32'h0040_0800; b_alu = 32'h0000_0044; b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        chk("h1.c1.sel",  {31'd0, b_sel},  32'd0);
        chk("h1.c1.busy", {31'd0, b_busy}, 32'd1);
        chk("h1.c1.ir",   b_ir,            32'h0040_0800);
        tick();
        chk("h1.c2.sel",  {31'd0, b_sel}, 32'd1);
        chk("h1.c2.data", b_data,         32'h0000_0044);
        chk("h1.c2.rv",   {31'd0, b_rv},  32'd0);
        tick();
        chk("h1.c3.rv",     {31'd0, b_rv},    32'd1);
        chk("h1.c3.result", b_result,         32'h0000_0044);
        chk("h1.c3.ready",  {31'd0, b_ready}, 32'd1);
        chk("h1.c3.sel",    {31'd0, b_sel},   32'd0);
        tick();
        chk("h1.c4.rv", {31'd0, b_rv}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
